// File: rtl/intr_ctrl.sv
// intr_ctrl: machine-level interrupt source block.
// Holds the mtime/mtimecmp timer, the MSIP bit and a synchronised,
// edge-latched external interrupt, arbitrates them against the MIE
// enables and hands one registered request plus its mcause value to the
// exception unit. Software reaches the registers over a word-addressed bus.
module intr_ctrl #(
  parameter int unsigned PRESCALE = 1  // core clocks per mtime tick, 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq_in,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie,
  input  logic        irq_ack,
  output logic        interrupt,
  output logic [31:0] irq_cause,
  output logic        mtip
);

  // Word index of each register (byte offset >> 2).
  localparam logic [2:0] A_MSIP      = 3'd0;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd1;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd2;
  localparam logic [2:0] A_MTIME_LO  = 3'd3;
  localparam logic [2:0] A_MTIME_HI  = 3'd4;
  localparam logic [2:0] A_EIP       = 3'd5;

  // Source index doubles as the bit position in mie and in the pending vector.
  localparam logic [1:0] SRC_MSI = 2'd0;
  localparam logic [1:0] SRC_MTI = 2'd1;
  localparam logic [1:0] SRC_MEI = 2'd2;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_t;

  // mcause value for a source: interrupt bit set, exception code in [3:0].
  function automatic logic [31:0] cause_of(input logic [1:0] src);
    logic [3:0] code;
    case (src)
      SRC_MSI: code = 4'd3;
      SRC_MTI: code = 4'd7;
      default: code = 4'd11;
    endcase
    return {1'b1, 27'b0, code};
  endfunction

  // Registers
  logic [15:0] r_prescale;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_eip;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_ext_prev;
  logic [31:0] r_rdata;
  state_t      r_state;
  logic        r_interrupt;
  logic [31:0] r_cause;
  logic [1:0]  r_src;

  // Combinational nets
  logic [2:0]  w_word;
  logic        w_wr_msip;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_time_lo;
  logic        w_wr_time_hi;
  logic        w_wr_eip;
  logic        w_tick;
  logic        w_ext_rise;
  logic [2:0]  w_en_pend;
  logic        w_any_pend;
  logic        w_latched_pend;
  logic [1:0]  w_win_src;
  logic [31:0] w_rdata;
  state_t      w_state_nxt;
  logic        w_int_nxt;
  logic [31:0] w_cause_nxt;
  logic [1:0]  w_src_nxt;
  logic        w_unused;

  // Byte-lane bits of the address carry no meaning on a word bus.
  assign w_unused = &{1'b0, bus_addr[1:0]};

  assign w_word       = bus_addr[4:2];
  assign w_wr_msip    = bus_we && (w_word == A_MSIP);
  assign w_wr_cmp_lo  = bus_we && (w_word == A_MTIMECMP_LO);
  assign w_wr_cmp_hi  = bus_we && (w_word == A_MTIMECMP_HI);
  assign w_wr_time_lo = bus_we && (w_word == A_MTIME_LO);
  assign w_wr_time_hi = bus_we && (w_word == A_MTIME_HI);
  assign w_wr_eip     = bus_we && (w_word == A_EIP);

  assign w_tick     = (r_prescale == PS_LAST);
  assign mtip       = (r_mtime >= r_mtimecmp);
  assign w_ext_rise = r_sync2 && !r_ext_prev;

  // Pending vector is ordered {MEI, MTI, MSI} to line up with mie.
  assign w_en_pend  = {3{mstatus_mie}} & mie & {r_eip, mtip, r_msip};
  assign w_any_pend = |w_en_pend;

  assign bus_rdata = r_rdata;
  assign interrupt = r_interrupt;
  assign irq_cause = r_cause;

  // Prescaler and mtime: a bus write to either half wins over the tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      r_prescale <= '0;
      r_mtime    <= '0;
    end else begin
      r_prescale <= w_tick ? 16'd0 : r_prescale + 16'd1;
      if (w_wr_time_lo) begin
        r_mtime[31:0] <= bus_wdata;
      end else if (w_wr_time_hi) begin
        r_mtime[63:32] <= bus_wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  // Software-owned registers: mtimecmp halves and the MSIP bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
    end else begin
      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= bus_wdata;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= bus_wdata;
      if (w_wr_msip)   r_msip            <= bus_wdata[0];
    end
  end

  // External request: two-flop synchroniser, edge detect, sticky EIP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_ext_prev <= 1'b0;
      r_eip      <= 1'b0;
    end else begin
      r_sync1    <= ext_irq_in;
      r_sync2    <= r_sync1;
      r_ext_prev <= r_sync2;
      // A new edge beats a simultaneous write-1-to-clear.
      if (w_ext_rise) begin
        r_eip <= 1'b1;
      end else if (w_wr_eip && bus_wdata[0]) begin
        r_eip <= 1'b0;
      end
    end
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_rdata = '0;
    case (w_word)
      A_MSIP:        w_rdata = {31'b0, r_msip};
      A_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      A_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      A_MTIME_LO:    w_rdata = r_mtime[31:0];
      A_MTIME_HI:    w_rdata = r_mtime[63:32];
      A_EIP:         w_rdata = {31'b0, r_eip};
      default:       w_rdata = '0;
    endcase
  end

  // Read data register: loads on bus_re, holds otherwise. Because it
  // samples before the edge, a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (bus_re) begin
      r_rdata <= w_rdata;
    end
  end

  // Fixed-priority winner among enabled, pending sources: MEI > MSI > MTI.
  always_comb begin
    w_win_src = SRC_MTI;
    if (w_en_pend[SRC_MEI]) begin
      w_win_src = SRC_MEI;
    end else if (w_en_pend[SRC_MSI]) begin
      w_win_src = SRC_MSI;
    end
  end

  // Is the source latched into the current request still enabled and pending?
  always_comb begin
    w_latched_pend = 1'b0;
    case (r_src)
      SRC_MSI: w_latched_pend = w_en_pend[0];
      SRC_MTI: w_latched_pend = w_en_pend[1];
      SRC_MEI: w_latched_pend = w_en_pend[2];
      default: w_latched_pend = 1'b0;
    endcase
  end

  // Request FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = r_interrupt;
    w_cause_nxt = r_cause;
    w_src_nxt   = r_src;
    case (r_state)
      ST_IDLE: begin
        if (w_any_pend) begin
          w_state_nxt = ST_REQ;
          w_int_nxt   = 1'b1;
          w_src_nxt   = w_win_src;
          w_cause_nxt = cause_of(w_win_src);
        end
      end
      ST_REQ: begin
        // Cause is frozen here; an ack beats a same-cycle withdrawal.
        if (irq_ack) begin
          w_state_nxt = ST_HOLD;
          w_int_nxt   = 1'b0;
        end else if (!w_latched_pend) begin
          w_state_nxt = ST_IDLE;
          w_int_nxt   = 1'b0;
          w_cause_nxt = '0;
        end
      end
      ST_HOLD: begin
        // Wait for the trap entry to clear mstatus.MIE; cause stays put.
        w_int_nxt = 1'b0;
        if (!mstatus_mie) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_int_nxt   = 1'b0;
        w_cause_nxt = '0;
      end
    endcase
  end

  // Request FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_interrupt <= 1'b0;
      r_cause     <= '0;
      r_src       <= SRC_MSI;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= w_int_nxt;
      r_cause     <= w_cause_nxt;
      r_src       <= w_src_nxt;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl (PRESCALE=1). Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rise.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_we;
  logic        bus_re;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        ext_irq_in;
  logic        mstatus_mie;
  logic [2:0]  mie;
  logic        irq_ack;
  logic        interrupt;
  logic [31:0] irq_cause;
  logic        mtip;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .ext_irq_in (ext_irq_in),
    .mstatus_mie(mstatus_mie),
    .mie        (mie),
    .irq_ack    (irq_ack),
    .interrupt  (interrupt),
    .irq_cause  (irq_cause),
    .mtip       (mtip)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
    ext_irq_in = 1'b0; mstatus_mie = 1'b0; mie = 3'b000; irq_ack = 1'b0;
    step(2);
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
    tests_run++; if (irq_cause !== 32'h0) begin tests_failed++; $display("FAIL reset_cause: got %h want 00000000", irq_cause); end
    tests_run++; if (bus_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 00000000", bus_rdata); end
    tests_run++; if (mtip !== 1'b0) begin tests_failed++; $display("FAIL reset_mtip: got %b want 0", mtip); end
    rst = 1'b0;
    bus_read(5'h08, rd);
    tests_run++; if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_cmp_hi: got %h want ffffffff", rd); end
    bus_read(5'h00, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_msip: got %h want 00000000", rd); end
  endtask

  task automatic test_timer_irq();
    bus_write(5'h08, 32'h0);
    bus_write(5'h04, 32'd20);
    bus_write(5'h10, 32'h0);
    bus_write(5'h0C, 32'h0);       // mtime = 0 after this edge
    mie = 3'b010; mstatus_mie = 1'b1;
    step(19);                      // mtime = 19
    tests_run++; if (mtip !== 1'b0) begin tests_failed++; $display("FAIL timer_mtip_19: got %b want 0", mtip); end
    step(1);                       // mtime = 20
    tests_run++; if (mtip !== 1'b1) begin tests_failed++; $display("FAIL timer_mtip_20: got %b want 1", mtip); end
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL timer_int_early: got %b want 0", interrupt); end
    step(1);
    tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL timer_int: got %b want 1", interrupt); end
    tests_run++; if (irq_cause !== 32'h8000_0007) begin tests_failed++; $display("FAIL timer_cause: got %h want 80000007", irq_cause); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL timer_ack_int: got %b want 0", interrupt); end
    tests_run++; if (irq_cause !== 32'h8000_0007) begin tests_failed++; $display("FAIL timer_hold_cause: got %h want 80000007", irq_cause); end
    step(2);
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL timer_hold_blocks: got %b want 0", interrupt); end
    mstatus_mie = 1'b0; step(1);   // HOLD -> IDLE
    mstatus_mie = 1'b1; step(1);   // IDLE re-requests on still-pending MTIP
    tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL timer_rereq: got %b want 1", interrupt); end
    mstatus_mie = 1'b0; step(1);   // enabled-pending drops -> withdraw
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL timer_withdraw_int: got %b want 0", interrupt); end
    tests_run++; if (irq_cause !== 32'h0) begin tests_failed++; $display("FAIL timer_withdraw_cause: got %h want 00000000", irq_cause); end
    mie = 3'b000;
  endtask

  task automatic test_priority();
    logic [31:0] rd;
    bus_write(5'h00, 32'h1);       // MSIP pending
    bus_write(5'h04, 32'h0);       // mtimecmp = 0 -> MTIP pending
    tests_run++; if (mtip !== 1'b1) begin tests_failed++; $display("FAIL prio_mtip: got %b want 1", mtip); end
    ext_irq_in = 1'b1;
    step(2);                       // sync1, sync2 loaded
    bus_read(5'h14, rd);           // sampled before the 3rd edge
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL eip_latency_2: got %h want 00000000", rd); end
    bus_read(5'h14, rd);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL eip_latency_3: got %h want 00000001", rd); end
    ext_irq_in = 1'b0;
    mie = 3'b111; mstatus_mie = 1'b1; step(1);
    tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL prio_int: got %b want 1", interrupt); end
    tests_run++; if (irq_cause !== 32'h8000_000B) begin tests_failed++; $display("FAIL prio_cause_mei: got %h want 8000000b", irq_cause); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL prio_ack: got %b want 0", interrupt); end
    mstatus_mie = 1'b0; step(1);   // HOLD -> IDLE
    tests_run++; if (irq_cause !== 32'h8000_000B) begin tests_failed++; $display("FAIL prio_cause_kept: got %h want 8000000b", irq_cause); end
    // Only MSI enabled now: a fresh request proves the FSM is back in IDLE.
    mie = 3'b001; mstatus_mie = 1'b1; step(1);
    tests_run++; if (irq_cause !== 32'h8000_0003) begin tests_failed++; $display("FAIL prio_cause_msi: got %h want 80000003", irq_cause); end
    mie = 3'b101; step(1);         // higher-priority MEI enabled while in REQ
    tests_run++; if (irq_cause !== 32'h8000_0003) begin tests_failed++; $display("FAIL req_frozen: got %h want 80000003", irq_cause); end
    mie = 3'b001;
  endtask

  task automatic test_withdraw();
    logic [31:0] rd;
    bus_write(5'h00, 32'h0);       // MSIP cleared at this edge
    tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL wd_still_req: got %b want 1", interrupt); end
    step(1);
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL wd_int: got %b want 0", interrupt); end
    tests_run++; if (irq_cause !== 32'h0) begin tests_failed++; $display("FAIL wd_cause: got %h want 00000000", irq_cause); end
    step(1);
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL wd_idle: got %b want 0", interrupt); end
    // Ack in the same cycle the withdrawal would happen: ack wins.
    bus_write(5'h00, 32'h1); step(1);
    tests_run++; if (irq_cause !== 32'h8000_0003) begin tests_failed++; $display("FAIL ackwd_req: got %h want 80000003", irq_cause); end
    bus_write(5'h00, 32'h0);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL ackwd_int: got %b want 0", interrupt); end
    tests_run++; if (irq_cause !== 32'h8000_0003) begin tests_failed++; $display("FAIL ackwd_cause: got %h want 80000003", irq_cause); end
    mstatus_mie = 1'b0; step(1);
    // EIP: write 0 has no effect, write 1 clears.
    bus_write(5'h14, 32'h0);
    bus_read(5'h14, rd);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL eip_w0: got %h want 00000001", rd); end
    bus_write(5'h14, 32'h1);
    bus_read(5'h14, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL eip_w1c: got %h want 00000000", rd); end
    bus_write(5'h04, 32'hFFFF_FFFF);
    bus_write(5'h08, 32'hFFFF_FFFF);
    mie = 3'b000;
  endtask

  task automatic test_mtime_wrap();
    logic [31:0] rd;
    bus_write(5'h10, 32'h0);
    bus_write(5'h0C, 32'hFFFF_FFFF);   // no increment on this edge
    bus_read(5'h0C, rd);
    tests_run++; if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mtime_wr_lo: got %h want ffffffff", rd); end
    bus_read(5'h10, rd);               // carry from the following tick
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL mtime_carry: got %h want 00000001", rd); end
    bus_write(5'h0C, 32'hFFFF_FFFF);
    bus_write(5'h10, 32'hFFFF_FFFF);   // mtime = 2^64-1
    step(2);                           // wraps to 0, then 1
    bus_read(5'h0C, rd);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL mtime_wrap_lo: got %h want 00000001", rd); end
    step(2);
    tests_run++; if (bus_rdata !== 32'h1) begin tests_failed++; $display("FAIL rdata_hold: got %h want 00000001", bus_rdata); end
    bus_read(5'h10, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL mtime_wrap_hi: got %h want 00000000", rd); end
  endtask

  task automatic test_bus_and_eip_collision();
    logic [31:0] rd;
    // Same-cycle write and read of MSIP returns the old value.
    bus_addr = 5'h00; bus_wdata = 32'hFFFF_FFFF; bus_we = 1'b1; bus_re = 1'b1;
    step(1);
    bus_we = 1'b0; bus_re = 1'b0;
    tests_run++; if (bus_rdata !== 32'h0) begin tests_failed++; $display("FAIL rw_same_old: got %h want 00000000", bus_rdata); end
    bus_read(5'h00, rd);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL msip_mask: got %h want 00000001", rd); end
    bus_write(5'h00, 32'h0);
    ext_irq_in = 1'b1;
    step(2);
    bus_write(5'h14, 32'h1);           // clear on the edge EIP gets set
    ext_irq_in = 1'b0;
    bus_read(5'h14, rd);
    tests_run++; if (rd !== 32'h1) begin tests_failed++; $display("FAIL eip_set_wins: got %h want 00000001", rd); end
    bus_read(5'h18, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read: got %h want 00000000", rd); end
    bus_write(5'h14, 32'h1);
  endtask

  task automatic test_reset_in_req();
    logic [31:0] rd;
    bus_write(5'h10, 32'h5);
    bus_write(5'h04, 32'h1234);
    bus_write(5'h00, 32'h1);
    mie = 3'b001; mstatus_mie = 1'b1;
    bus_read(5'h00, rd);               // also leaves REQ active
    tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL rreq_pre: got %b want 1", interrupt); end
    rst = 1'b1; step(1);
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL rreq_int: got %b want 0", interrupt); end
    tests_run++; if (irq_cause !== 32'h0) begin tests_failed++; $display("FAIL rreq_cause: got %h want 00000000", irq_cause); end
    tests_run++; if (bus_rdata !== 32'h0) begin tests_failed++; $display("FAIL rreq_rdata: got %h want 00000000", bus_rdata); end
    rst = 1'b0;
    bus_read(5'h0C, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rreq_mtime_lo: got %h want 00000000", rd); end
    bus_read(5'h10, rd);
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rreq_mtime_hi: got %h want 00000000", rd); end
    bus_read(5'h04, rd);
    tests_run++; if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rreq_cmp_lo: got %h want ffffffff", rd); end
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL rreq_idle: got %b want 0", interrupt); end
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_priority();
    test_withdraw();
    test_mtime_wrap();
    test_bus_and_eip_collision();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Machine-level interrupt source block that sits directly upstream of the exception unit and drives its `interrupt` input. It contains:
- a 64-bit mtime/mtimecmp timer;
- a software-interrupt bit (MSIP);
- a synchronised, edge-latched external interrupt.

It arbitrates these three sources against the MIE enables and presents a cause code to the trap handler. Software programs it over a simple word-addressed register bus from the MEM stage.

Parameters:
PRESCALE, 1, core clocks per mtime increment (valid range 1..65535).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
bus_we  in  1  register write strobe
bus_re  in  1  register read strobe
bus_addr  in  5  byte offset; bits[1:0] ignored
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
ext_irq_in  in  1  asynchronous external interrupt request
mstatus_mie  in  1  mstatus[3] from CSR file
mie  in  3  enables {MEIE, MTIE, MSIE}
irq_ack  in  1  one-cycle pulse: exception unit accepted the trap
interrupt  out  1  interrupt request to exception unit, registered
irq_cause  out  32  mcause value of the current request
mtip  out  1  raw timer-pending flag, for CSR mip

Behaviour:
Register map (byte offset):
- 0x00 MSIP: bit0 is R/W; other bits read 0.
- 0x04 MTIMECMP_LO.
- 0x08 MTIMECMP_HI.
- 0x0C MTIME_LO.
- 0x10 MTIME_HI.
- 0x14 EIP: bit0 = external pending. Writing 1 clears it; writing 0 has no effect.
- Any other offset: reads return 0; writes are ignored.

Bus timing:
- Writes take effect at the rising edge on which bus_we=1.
- bus_rdata updates one cycle after bus_re and holds its value until the next read.
- If bus_we and bus_re hit the same address in the same cycle, the read returns the old value.

Reset values (rst=1, applied at the next edge):
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, MSIP=0, EIP=0.
- Prescaler=0, both sync flops=0, edge-detect history=0.
- State=IDLE, interrupt=0, irq_cause=0, bus_rdata=0.
- Reset asserted in any state aborts the request immediately.

Timer:
- The prescaler counts 0..PRESCALE-1. mtime increments by 1 on the cycle the prescaler equals PRESCALE-1, then the prescaler returns to 0.
- With PRESCALE=1, mtime increments every cycle.
- mtime wraps from 2^64-1 to 0.
- A bus write to MTIME_LO or MTIME_HI replaces that half and suppresses the increment in that cycle. The other half is unchanged; no carry is generated.
- mtip = (mtime >= mtimecmp), 64-bit unsigned compare, combinational from the registers.

External interrupt:
- ext_irq_in passes through a 2-flop synchroniser.
- A rising edge of the synchronised signal sets EIP.
- Set and software clear in the same cycle: set wins.
- Minimum latency from the ext_irq_in rise to EIP=1 is 3 edges.

Arbitration:
- Enabled pending per source = mstatus_mie & mie[k] & pending[k].
- Priority, highest first: MEI (code 11) > MSI (code 3) > MTI (code 7).
- irq_cause = {1'b1, 27'b0, code}.

State machine:
- IDLE:
  - If any source is enabled and pending, go to REQ on the next edge, with interrupt=1 and irq_cause latched for the winning source.
- REQ:
  - interrupt stays high and irq_cause is frozen, even if a higher-priority source arrives.
  - irq_ack → go to HOLD with interrupt=0.
  - The latched source's enabled-pending term drops before any ack → withdraw: go to IDLE with interrupt=0 and irq_cause=0.
  - irq_ack and withdrawal in the same cycle: the ack wins.
- HOLD:
  - Blocks re-requests until the trap has cleared MIE.
  - Return to IDLE on the first cycle with mstatus_mie=0.
  - irq_cause is kept unchanged for the handler.

Test Plan:
1. PRESCALE=1, write MTIMECMP_HI=0 and MTIMECMP_LO=20, mie=3'b010, mstatus_mie=1 → mtip rises when mtime reaches 20; interrupt=1 on the next edge; irq_cause=0x80000007.
2. Pulse ext_irq_in together with pending MSIP and MTIP, all enabled → irq_cause=0x8000000B. After irq_ack, interrupt=0 (HOLD). Drive mstatus_mie=0 → IDLE.
3. In REQ with MSIP, write MSIP=0 before ack → interrupt drops next edge, irq_cause=0, state IDLE.
4. Write MTIME_LO=0xFFFFFFFF and MTIME_HI=0xFFFFFFFF, then run 1 cycle → mtime=0. Read MTIME_LO → bus_rdata=0x00000001 or greater, one cycle after bus_re.
5. Write EIP=1 on the same edge the synchroniser produces a rising edge → EIP stays 1. Read offset 0x18 → bus_rdata=0.
6. Assert rst while in REQ → next edge: interrupt=0, mtime=0, mtimecmp all ones, state IDLE.
